reg_seq_ctrl: RTL and testbench
===============================

// Module: reg_seq_ctrl
// PURPOSE
//  Multi-cycle instruction sequencer for the 4x16 register group.
//  - Accepts one 16-bit instruction per valid/ready handshake.
//  - Reads rd/rs through the group's en_in/en_out read port and computes the result in an ALU.
//  - Writes the result back through the one-hot reg_en/d_in write port.
//  - Sits between the instruction source and the register group; it is the only master of both ports.
// PARAMETERS
//  DW        16  datapath width; must match the register group width.
//  WAIT_MAX  4   cycles allowed in WAIT for rg_en_out before the timeout error fires.
// PORTS
//  clk          in   1   system clock; every flop uses the rising edge.
//  rst          in   1   reset, asynchronous and active-high.
//  instr_valid  in   1   instruction available.
//  instr_ready  out  1   controller can accept an instruction; high only in IDLE.
//  instr        in   16  instruction: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm8.
//  rg_en_in     out  1   read request to the register group.
//  rg_rd        out  2   read address A (rd).
//  rg_rs        out  2   read address B (rs).
//  rg_en_out    in   1   read data valid from the register group.
//  rg_rd_q      in   DW  read data A.
//  rg_rs_q      in   DW  read data B.
//  rg_reg_en    out  4   one-hot write enable.
//  rg_d_in      out  DW  write data.
//  busy         out  1   high in any state other than IDLE.
//  done         out  1   one-cycle pulse when an instruction retires.
//  err          out  1   one-cycle pulse, coincident with done, on illegal op or timeout.
//  flag_z       out  1   zero flag.
//  flag_c       out  1   carry/borrow flag.
// BEHAVIOUR
//  Reset: all outputs 0 except instr_ready=1; state=IDLE; flags=0.
//  - Reset may assert in any state; it aborts the instruction and no write occurs.
//  Handshake: the instruction is accepted when instr_valid & instr_ready; op, rd, rs and imm8 are captured.
//  - instr_valid held high while busy causes no effect; the next instruction is taken in IDLE.
//  Opcodes (op -> result): 0 NOP; 1 MOV rs; 2 ADD rd+rs; 3 SUB rd-rs; 4 AND; 5 OR; 6 XOR;
//  - 7 LDI {8'b0,imm8}; 8 SHL rd<<1; 9..15 illegal.
//  FSM states: IDLE, READ, WAIT, EXEC, WB.
//  - IDLE -> READ for ops 1-6 and 8.
//  - IDLE -> EXEC for LDI.
//  - IDLE -> WB with no write for NOP or an illegal op; an illegal op also pulses err.
//  - READ: rg_en_in=1 for exactly one cycle; rg_rd/rg_rs driven from the captured fields and held until IDLE.
//  - WAIT: rg_rd_q/rg_rs_q are latched in the cycle rg_en_out=1, then -> EXEC.
//  - WAIT timeout: after WAIT_MAX cycles with rg_en_out=0 -> WB with no write and err pulse; flags unchanged.
//  - EXEC: the result is registered into rg_d_in, the flags update, then -> WB.
//  - WB: rg_reg_en=1<<rd for one cycle if a write is pending, else 4'b0000; done=1; -> IDLE.
//  Latency (accept edge = cycle 0):
//  - ALU ops: done in cycle 4; instr_ready returns in cycle 5.
//  - LDI: done in cycle 2.
//  - NOP/illegal: done in cycle 1.
//  Arithmetic: all ops are modulo 2^DW.
//  - ADD: C = carry-out.
//  - SUB: C = borrow (rd<rs, unsigned).
//  - SHL: C = rd[DW-1].
//  - AND/OR/XOR: C cleared. MOV/LDI: C unchanged.
//  - Z = (result==0) for every writing op.
//  Invariants: rg_reg_en is zero or one-hot and is non-zero only in WB; rg_en_in is high only in READ.
// STRUCTURE
//  Shared package reg_ctrl_pkg: opcode constants, FSM state encoding, instruction field offsets.
//  Sub-module alu_core (combinational): inputs op, a, b, imm8; outputs result, carry, zero.
//  The FSM, capture registers and timeout counter live in reg_seq_ctrl.
// TESTING
//  1. Assert rst during WAIT of an ADD -> outputs 0 and ready=1 immediately; rg_reg_en never non-zero; flags 0.
//  2. LDI r2,0xA5 -> cycle 2 shows rg_reg_en=4'b0100, rg_d_in=16'h00A5, done=1; Z=0.
//  3. ADD r1,r3 with model q1=16'hFFFF, q3=16'h0001:
//     - cycle 1: rg_rd=2'b01, rg_rs=2'b11.
//     - cycle 4: rg_d_in=16'h0000, rg_reg_en=4'b0010, Z=1, C=1.
//  4. SUB r0,r0 with q0=16'h1234 -> result 16'h0000, Z=1, C=0.
//     SUB r0,r1 with q0=1, q1=2 -> result 16'hFFFF, C=1.
//  5. Model holds rg_en_out=0 -> after 4 WAIT cycles: done=1, err=1, rg_reg_en=0, flags unchanged.
//  6. instr_valid held high for op=4'hF followed by MOV r3,r0:
//     - first: err and done in cycle 1, no write.
//     - second: accepted only on instr_ready; rg_reg_en=4'b1000 in its cycle 4.

Source files
------------

// File: rtl/reg_seq_ctrl_pkg.sv
// Shared definitions for the register-group instruction sequencer:
// instruction field layout, opcode values, FSM state encoding and small
// decode helpers used by both the controller and its ALU.
package reg_ctrl_pkg;

   // Instruction word layout: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm8
   localparam int INSTR_W = 16;
   localparam int OP_LSB  = 12;
   localparam int OP_W    = 4;
   localparam int RD_LSB  = 10;
   localparam int RS_LSB  = 8;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 8;

   // Opcodes; 9..15 are illegal
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_MOV = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_LDI = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_EXEC,
      ST_WB
   } state_t;

   // Ops that need operands fetched from the register group
   function automatic logic op_reads(input logic [3:0] op);
      return ((op >= OP_MOV) && (op <= OP_XOR)) || (op == OP_SHL);
   endfunction

   // Ops that overwrite the carry flag (MOV and LDI leave it alone)
   function automatic logic op_sets_carry(input logic [3:0] op);
      return ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_SHL);
   endfunction

   function automatic logic op_illegal(input logic [3:0] op);
      return op > OP_SHL;
   endfunction

   function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/reg_seq_ctrl_if.sv
// Bundle of the instruction handshake, the register-group read/write ports
// and the status outputs. The sequencer is the master of everything here;
// the slave side is the instruction source plus the register group.
interface reg_seq_ctrl_if #(
   parameter int DW = 16
);
   import reg_ctrl_pkg::*;

   // Instruction handshake
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;

   // Register group read port
   logic               rg_en_in;
   logic [1:0]         rg_rd;
   logic [1:0]         rg_rs;
   logic               rg_en_out;
   logic [DW-1:0]      rg_rd_q;
   logic [DW-1:0]      rg_rs_q;

   // Register group write port
   logic [3:0]         rg_reg_en;
   logic [DW-1:0]      rg_d_in;

   // Status
   logic               busy;
   logic               done;
   logic               err;
   logic               flag_z;
   logic               flag_c;

   modport master (
      input  instr_valid, instr, rg_en_out, rg_rd_q, rg_rs_q,
      output instr_ready, rg_en_in, rg_rd, rg_rs, rg_reg_en, rg_d_in,
             busy, done, err, flag_z, flag_c
   );

   modport slave (
      output instr_valid, instr, rg_en_out, rg_rd_q, rg_rs_q,
      input  instr_ready, rg_en_in, rg_rd, rg_rs, rg_reg_en, rg_d_in,
             busy, done, err, flag_z, flag_c
   );

endinterface

// File: rtl/reg_seq_ctrl_alu.sv
// Combinational ALU for the sequencer. All results wrap modulo 2^DW; the
// extra top bit of the internal sum carries the carry/borrow/shift-out.
module alu_core
   import reg_ctrl_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [3:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [7:0]    imm8,
   output logic [DW-1:0] result,
   output logic          carry,
   output logic          zero
);

   logic [DW:0] wide;

   // Compute a DW+1 bit result whose MSB is the carry for this op
   always_comb begin
      // NOTE: default first so every path assigns wide and no latch is inferred.
      wide = '0;
      case (op)
         OP_MOV:  wide = {1'b0, b};
         OP_ADD:  wide = {1'b0, a} + {1'b0, b};
         OP_SUB:  wide = {1'b0, a} - {1'b0, b};   // MSB set means borrow
         OP_AND:  wide = {1'b0, a & b};
         OP_OR:   wide = {1'b0, a | b};
         OP_XOR:  wide = {1'b0, a ^ b};
         OP_LDI:  wide = {{(DW + 1 - IMM_W){1'b0}}, imm8};
         OP_SHL:  wide = {a, 1'b0};               // MSB is the bit shifted out
         default: wide = '0;
      endcase
   end

   assign result = wide[DW-1:0];
   assign carry  = wide[DW];
   assign zero   = (wide[DW-1:0] == '0);

endmodule

// File: rtl/reg_seq_ctrl.sv
// Multi-cycle instruction sequencer for the 4x16 register group. Takes one
// instruction per handshake, fetches rd/rs over the read port, runs the ALU
// and writes the result back through the one-hot write port. All outputs
// are registered and change only on state transitions.
module reg_seq_ctrl
   import reg_ctrl_pkg::*;
#(
   parameter int DW       = 16,
   parameter int WAIT_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   reg_seq_ctrl_if.master bus
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   state_t          state;
   logic [3:0]      op_q;
   logic [1:0]      rd_q;
   logic [1:0]      rs_q;
   logic [7:0]      imm_q;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic [CNT_W-1:0] wait_cnt;

   logic [3:0]      op_in;
   logic [1:0]      rd_in;
   logic [1:0]      rs_in;
   logic [7:0]      imm_in;

   logic [DW-1:0]   alu_res;
   logic            alu_c;
   logic            alu_z;

   assign op_in  = bus.instr[OP_LSB  +: OP_W];
   assign rd_in  = bus.instr[RD_LSB  +: 2];
   assign rs_in  = bus.instr[RS_LSB  +: 2];
   assign imm_in = bus.instr[IMM_LSB +: IMM_W];

   alu_core #(
      .DW (DW)
   ) u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .imm8   (imm_q),
      .result (alu_res),
      .carry  (alu_c),
      .zero   (alu_z)
   );

   // Sequencer FSM with capture registers, timeout counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: every capture register is reset too, so a reset mid-instruction leaves no stale operands behind.
         state           <= ST_IDLE;
         op_q            <= '0;
         rd_q            <= '0;
         rs_q            <= '0;
         imm_q           <= '0;
         a_q             <= '0;
         b_q             <= '0;
         wait_cnt        <= '0;
         bus.instr_ready <= 1'b1;
         bus.rg_en_in    <= 1'b0;
         bus.rg_rd       <= '0;
         bus.rg_rs       <= '0;
         bus.rg_reg_en   <= '0;
         bus.rg_d_in     <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.err         <= 1'b0;
         bus.flag_z      <= 1'b0;
         bus.flag_c      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         case (state)
            ST_IDLE: begin
               if (bus.instr_valid && bus.instr_ready) begin
                  op_q            <= op_in;
                  rd_q            <= rd_in;
                  rs_q            <= rs_in;
                  imm_q           <= imm_in;
                  bus.instr_ready <= 1'b0;
                  bus.busy        <= 1'b1;
                  if (op_reads(op_in)) begin
                     state        <= ST_READ;
                     bus.rg_en_in <= 1'b1;
                     bus.rg_rd    <= rd_in;
                     bus.rg_rs    <= rs_in;
                  end else if (op_in == OP_LDI) begin
                     state <= ST_EXEC;
                  end else begin
                     // NOP retires at once; an illegal op retires with err
                     state    <= ST_WB;
                     bus.done <= 1'b1;
                     bus.err  <= op_illegal(op_in);
                  end
               end
            end

            ST_READ: begin
               bus.rg_en_in <= 1'b0;
               wait_cnt     <= '0;
               state        <= ST_WAIT;
            end

            ST_WAIT: begin
               if (bus.rg_en_out) begin
                  a_q   <= bus.rg_rd_q;
                  b_q   <= bus.rg_rs_q;
                  state <= ST_EXEC;
               end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                  // Register group never answered: retire without a write
                  state    <= ST_WB;
                  bus.done <= 1'b1;
                  bus.err  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            ST_EXEC: begin
               bus.rg_d_in   <= alu_res;
               bus.flag_z    <= alu_z;
               if (op_sets_carry(op_q)) begin
                  bus.flag_c <= alu_c;
               end
               bus.rg_reg_en <= reg_onehot(rd_q);
               bus.done      <= 1'b1;
               state         <= ST_WB;
            end

            ST_WB: begin
               bus.rg_reg_en   <= '0;
               bus.done        <= 1'b0;
               bus.err         <= 1'b0;
               bus.rg_rd       <= '0;
               bus.rg_rs       <= '0;
               bus.busy        <= 1'b0;
               bus.instr_ready <= 1'b1;
               state           <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Directed testbench for reg_seq_ctrl. A small register-group model answers
// read requests one cycle after rg_en_in and applies write-backs. Inputs
// change on the falling edge; outputs are sampled on the falling edge.
module tb_reg_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int errors = 0;
   int checks = 0;

   reg_seq_ctrl_if #(.DW(16)) ifc ();

   reg_seq_ctrl #(
      .DW       (16),
      .WAIT_MAX (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.master)
   );

   always #5 clk = ~clk;

   // Register group model
   logic [15:0] rf [4];
   logic        model_en = 1'b1;
   logic        ld_en    = 1'b0;
   logic [1:0]  ld_idx   = 2'd0;
   logic [15:0] ld_val   = 16'h0;
   int          wr_count = 0;

   // Answer reads one cycle after the request; apply loads and write-backs
   always @(posedge clk) begin
      if (model_en && ifc.rg_en_in) begin
         ifc.rg_en_out <= 1'b1;
         ifc.rg_rd_q   <= rf[ifc.rg_rd];
         ifc.rg_rs_q   <= rf[ifc.rg_rs];
      end else begin
         ifc.rg_en_out <= 1'b0;
      end
      if (ld_en) begin
         rf[ld_idx] <= ld_val;
      end else if (ifc.rg_reg_en != 4'b0000) begin
         for (int i = 0; i < 4; i++) begin
            if (ifc.rg_reg_en[i]) rf[i] <= ifc.rg_d_in;
         end
         wr_count <= wr_count + 1;
      end
   end

   // Called at a falling edge with the DUT idle; returns at the falling edge of cycle 1
   task automatic send(input logic [15:0] ins);
      ifc.instr       = ins;
      ifc.instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.instr_valid = 1'b0;
   endtask

   task automatic set_reg(input logic [1:0] idx, input logic [15:0] val);
      ld_idx = idx;
      ld_val = val;
      ld_en  = 1'b1;
      @(negedge clk);
      ld_en  = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (ifc.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ifc.instr_ready); end
      checks++; if ({ifc.busy, ifc.done, ifc.err, ifc.rg_en_in} !== 4'b0000) begin errors++; $display("FAIL reset_ctl: got %b want 0000", {ifc.busy, ifc.done, ifc.err, ifc.rg_en_in}); end
      checks++; if ({ifc.rg_reg_en, ifc.rg_rd, ifc.rg_rs, ifc.rg_d_in} !== 24'h0) begin errors++; $display("FAIL reset_ports: got %h want 000000", {ifc.rg_reg_en, ifc.rg_rd, ifc.rg_rs, ifc.rg_d_in}); end
      checks++; if ({ifc.flag_z, ifc.flag_c} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {ifc.flag_z, ifc.flag_c}); end
   endtask

   task automatic test_ldi;
      send(16'h78A5);  // LDI r2, 0xA5
      checks++; if ({ifc.busy, ifc.instr_ready, ifc.done} !== 3'b100) begin errors++; $display("FAIL ldi_c1: got %b want 100", {ifc.busy, ifc.instr_ready, ifc.done}); end
      @(negedge clk);
      checks++; if (ifc.rg_reg_en !== 4'b0100) begin errors++; $display("FAIL ldi_reg_en: got %b want 0100", ifc.rg_reg_en); end
      checks++; if (ifc.rg_d_in !== 16'h00A5) begin errors++; $display("FAIL ldi_d_in: got %h want 00a5", ifc.rg_d_in); end
      checks++; if ({ifc.done, ifc.err, ifc.flag_z} !== 3'b100) begin errors++; $display("FAIL ldi_done: got %b want 100", {ifc.done, ifc.err, ifc.flag_z}); end
      @(negedge clk);
      checks++; if ({ifc.instr_ready, ifc.rg_reg_en} !== 5'b1_0000) begin errors++; $display("FAIL ldi_c3: got %b want 10000", {ifc.instr_ready, ifc.rg_reg_en}); end
      checks++; if (rf[2] !== 16'h00A5) begin errors++; $display("FAIL ldi_rf2: got %h want 00a5", rf[2]); end
   endtask

   task automatic test_add;
      set_reg(2'd1, 16'hFFFF);
      set_reg(2'd3, 16'h0001);
      send(16'h2700);  // ADD r1, r3
      checks++; if ({ifc.rg_rd, ifc.rg_rs, ifc.rg_en_in} !== 5'b01_11_1) begin errors++; $display("FAIL add_c1: got %b want 01111", {ifc.rg_rd, ifc.rg_rs, ifc.rg_en_in}); end
      @(negedge clk);
      checks++; if (ifc.rg_en_in !== 1'b0) begin errors++; $display("FAIL add_en_in_c2: got %b want 0", ifc.rg_en_in); end
      @(negedge clk);
      checks++; if ({ifc.done, ifc.rg_reg_en} !== 5'b0_0000) begin errors++; $display("FAIL add_c3: got %b want 00000", {ifc.done, ifc.rg_reg_en}); end
      @(negedge clk);
      checks++; if (ifc.rg_d_in !== 16'h0000) begin errors++; $display("FAIL add_d_in: got %h want 0000", ifc.rg_d_in); end
      checks++; if (ifc.rg_reg_en !== 4'b0010) begin errors++; $display("FAIL add_reg_en: got %b want 0010", ifc.rg_reg_en); end
      checks++; if ({ifc.done, ifc.flag_z, ifc.flag_c} !== 3'b111) begin errors++; $display("FAIL add_flags: got %b want 111", {ifc.done, ifc.flag_z, ifc.flag_c}); end
      @(negedge clk);
      checks++; if (ifc.instr_ready !== 1'b1) begin errors++; $display("FAIL add_ready_c5: got %b want 1", ifc.instr_ready); end
   endtask

   task automatic test_sub;
      set_reg(2'd0, 16'h1234);
      send(16'h3000);  // SUB r0, r0
      repeat (3) @(negedge clk);
      checks++; if ({ifc.rg_reg_en, ifc.rg_d_in} !== 20'h1_0000) begin errors++; $display("FAIL sub_same: got %h want 10000", {ifc.rg_reg_en, ifc.rg_d_in}); end
      checks++; if ({ifc.flag_z, ifc.flag_c} !== 2'b10) begin errors++; $display("FAIL sub_same_flags: got %b want 10", {ifc.flag_z, ifc.flag_c}); end
      @(negedge clk);
      set_reg(2'd0, 16'h0001);
      set_reg(2'd1, 16'h0002);
      send(16'h3100);  // SUB r0, r1
      repeat (3) @(negedge clk);
      checks++; if ({ifc.rg_reg_en, ifc.rg_d_in} !== 20'h1_FFFF) begin errors++; $display("FAIL sub_borrow: got %h want 1ffff", {ifc.rg_reg_en, ifc.rg_d_in}); end
      checks++; if ({ifc.flag_z, ifc.flag_c} !== 2'b01) begin errors++; $display("FAIL sub_borrow_flags: got %b want 01", {ifc.flag_z, ifc.flag_c}); end
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int wr_before;
      wr_before = wr_count;
      model_en  = 1'b0;
      send(16'h4B00);  // AND r2, r3 with no read response
      repeat (4) @(negedge clk);  // cycle 5: last WAIT cycle
      checks++; if ({ifc.done, ifc.err, ifc.busy} !== 3'b001) begin errors++; $display("FAIL tmo_early: got %b want 001", {ifc.done, ifc.err, ifc.busy}); end
      @(negedge clk);             // cycle 6
      checks++; if ({ifc.done, ifc.err, ifc.rg_reg_en} !== 6'b11_0000) begin errors++; $display("FAIL tmo_retire: got %b want 110000", {ifc.done, ifc.err, ifc.rg_reg_en}); end
      checks++; if ({ifc.flag_z, ifc.flag_c} !== 2'b01) begin errors++; $display("FAIL tmo_flags: got %b want 01", {ifc.flag_z, ifc.flag_c}); end
      @(negedge clk);
      checks++; if ({ifc.instr_ready, ifc.err} !== 2'b10) begin errors++; $display("FAIL tmo_after: got %b want 10", {ifc.instr_ready, ifc.err}); end
      checks++; if (wr_count !== wr_before) begin errors++; $display("FAIL tmo_no_write: got %0d want %0d", wr_count, wr_before); end
      model_en = 1'b1;
   endtask

   task automatic test_back_to_back;
      int waits;
      set_reg(2'd0, 16'h5A5A);
      ifc.instr       = 16'hF000;  // illegal op 15
      ifc.instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);              // cycle 1 of the illegal op
      checks++; if ({ifc.done, ifc.err, ifc.rg_reg_en, ifc.instr_ready} !== 7'b11_0000_0) begin errors++; $display("FAIL ill_retire: got %b want 1100000", {ifc.done, ifc.err, ifc.rg_reg_en, ifc.instr_ready}); end
      ifc.instr = 16'h1C00;        // MOV r3, r0 with valid still high
      waits = 0;
      while ((ifc.instr_ready !== 1'b1) && (waits < 8)) begin
         @(negedge clk);
         waits++;
      end
      checks++; if (waits !== 1) begin errors++; $display("FAIL b2b_ready_wait: got %0d cycles want 1", waits); end
      @(posedge clk);              // MOV accept edge
      @(negedge clk);
      ifc.instr_valid = 1'b0;
      checks++; if ({ifc.busy, ifc.rg_rd, ifc.rg_rs} !== 5'b1_11_00) begin errors++; $display("FAIL mov_c1: got %b want 11100", {ifc.busy, ifc.rg_rd, ifc.rg_rs}); end
      repeat (3) @(negedge clk);   // cycle 4
      checks++; if (ifc.rg_reg_en !== 4'b1000) begin errors++; $display("FAIL mov_reg_en: got %b want 1000", ifc.rg_reg_en); end
      checks++; if (ifc.rg_d_in !== 16'h5A5A) begin errors++; $display("FAIL mov_d_in: got %h want 5a5a", ifc.rg_d_in); end
      checks++; if ({ifc.done, ifc.err, ifc.flag_z, ifc.flag_c} !== 4'b1001) begin errors++; $display("FAIL mov_flags: got %b want 1001", {ifc.done, ifc.err, ifc.flag_z, ifc.flag_c}); end
      @(negedge clk);
      checks++; if ({ifc.instr_ready, ifc.busy} !== 2'b10) begin errors++; $display("FAIL mov_c5: got %b want 10", {ifc.instr_ready, ifc.busy}); end
   endtask

   task automatic test_reset_in_wait;
      int wr_before;
      set_reg(2'd1, 16'hFFFF);
      set_reg(2'd3, 16'h0001);
      wr_before = wr_count;
      send(16'h2700);  // ADD r1, r3
      @(negedge clk);  // cycle 2: WAIT
      rst = 1'b1;
      #1;
      checks++; if ({ifc.instr_ready, ifc.busy, ifc.done, ifc.err, ifc.rg_en_in} !== 5'b10000) begin errors++; $display("FAIL rstw_ctl: got %b want 10000", {ifc.instr_ready, ifc.busy, ifc.done, ifc.err, ifc.rg_en_in}); end
      checks++; if ({ifc.rg_reg_en, ifc.rg_rd, ifc.rg_rs, ifc.flag_z, ifc.flag_c} !== 10'h0) begin errors++; $display("FAIL rstw_ports: got %b want 0000000000", {ifc.rg_reg_en, ifc.rg_rd, ifc.rg_rs, ifc.flag_z, ifc.flag_c}); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (ifc.rg_reg_en !== 4'b0000) begin errors++; $display("FAIL rstw_reg_en[%0d]: got %b want 0000", i, ifc.rg_reg_en); end
      end
      checks++; if (wr_count !== wr_before) begin errors++; $display("FAIL rstw_no_write: got %0d want %0d", wr_count, wr_before); end
      checks++; if ({ifc.instr_ready, ifc.busy} !== 2'b10) begin errors++; $display("FAIL rstw_idle: got %b want 10", {ifc.instr_ready, ifc.busy}); end
   endtask

   initial begin
      ifc.instr_valid = 1'b0;
      ifc.instr       = 16'h0000;
      test_reset();
      test_ldi();
      test_add();
      test_sub();
      test_timeout();
      test_back_to_back();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Bound on total run time
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
